// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Purpose:
//   Adds two WIDTH-bit operands using one 4-bit ripple adder, one nibble per
//   cycle, least significant nibble first. A registered carry links the
//   nibbles. The block reassembles the WIDTH-bit sum and reports the final
//   carry and signed overflow. Operands arrive through a valid/ready input
//   handshake. The result leaves through a valid/ready output handshake.
//
// Configuration macro:
//   NSA_SUB_EN - When defined, the block has a `sub` port. With sub=1 it
//                computes a - b as a + ~b + 1, and cin is ignored. When
//                undefined, the block performs addition only.
//
// Parameters:
//   WIDTH      - operand/result width; a multiple of 4 and >= 4 (default 16)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand set valid
//   in_ready   out  block can accept operands (IDLE only)
//   a, b       in   operands, sampled on the input handshake
//   cin        in   carry into nibble 0, sampled on the input handshake
//   sub        in   subtract select (NSA_SUB_EN builds only)
//   sum        out  registered WIDTH-bit result
//   cout       out  carry out of the most significant nibble
//   overflow   out  signed two's-complement overflow of the full result
//   out_valid  out  result valid (DONE state)
//   out_ready  in   consumer accepts the result
// -----------------------------------------------------------------------------

// 4-bit ripple adder stage shared by every nibble of the serial datapath.
module full_adder_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  assign {o_cout, o_sum} = 5'(i_a) + 5'(i_b) + 5'(i_cin);
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;      // latched operand A
  logic [WIDTH-1:0] r_b;      // latched effective operand B (inverted for subtract)
  logic             r_c;      // inter-nibble carry
  logic [KW-1:0]    r_k;      // index of the nibble being computed

  // Effective B and carry-in, resolved once at the handshake so the RUN
  // datapath is identical for add and subtract.
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

`ifdef NSA_SUB_EN
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : cin;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = cin;
`endif

  // Bit offset of the current nibble: 4*k.
  logic [KW+1:0] w_base;
  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [3:0]    w_s_nib;
  logic          w_c_nib;
  logic          w_last;

  assign w_base  = {r_k, 2'b00};
  assign w_a_nib = r_a[w_base +: 4];
  assign w_b_nib = r_b[w_base +: 4];
  assign w_last  = (r_k == KW'(N - 1));

  full_adder_4bit u_fa (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_c),
    .o_sum  (w_s_nib),
    .o_cout (w_c_nib)
  );

  // NOTE: every register here, including the operand holding registers, is
  // in the reset branch so no output or internal value depends on power-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= 1'b0;
      r_k       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every read below sees the
      // value from before this edge regardless of statement order.
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= w_b_eff;
            r_c      <= w_cin_eff;
            r_k      <= '0;
            sum      <= '0;
            in_ready <= 1'b0;
            r_state  <= S_RUN;
          end
        end

        S_RUN: begin
          sum[w_base +: 4] <= w_s_nib;
          r_c              <= w_c_nib;
          if (w_last) begin
            // Overflow: operands agree in sign but the result sign differs.
            cout      <= w_c_nib;
            overflow  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                         (w_s_nib[3] != r_a[WIDTH-1]);
            out_valid <= 1'b1;
            r_k       <= '0;
            r_state   <= S_DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed bench for nibble_serial_adder at WIDTH=16. It covers the reset
// state, several add vectors with hand-computed results, the exact latency,
// backpressure in DONE, an abort by reset during RUN, and subtraction when
// NSA_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
`ifdef NSA_SUB_EN
  logic             sub_i = 1'b0;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NSA_SUB_EN
    .sub       (sub_i),
`endif
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and complete the input handshake (edge E0).
  task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD;   // later input changes must not matter
    b = 16'hBEEF;
    cin = 1'b1;
  endtask

  // Count edges after E0 until out_valid rises (bounded).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic run_add(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] es, input logic ec, input logic eo);
    int cyc;
    start_op(va, vb, vc);
    wait_done(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    #12;
    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    run_add("v1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_add("vffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_add("v7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_add("v8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_add("vcin",  16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
    // Sum holds in IDLE.
    tick();
    check("idle_hold_sum", 32'(sum), 32'h0100);

    // Backpressure: ABCD + 1111 = BCDE, no carry, no overflow.
    start_op(16'hABCD, 16'h1111, 1'b0);
    wait_done(cyc);
    check("bp_latency", 32'(cyc), 32'd4);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = 16'h0F0F;
        b = 16'h0F0F;
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum", 32'(sum), 32'hBCDE);
      check("bp_cout", 32'(cout), 32'd0);
      check("bp_ovf", 32'(overflow), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_sum", 32'(sum), 32'hBCDE);

    // Abort by reset after 2 RUN cycles.
    start_op(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready_after", 32'(in_ready), 32'd1);
    run_add("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

`ifdef NSA_SUB_EN
    // 5 - 7 = FFFE with borrow (cout=0).
    sub_i = 1'b1;
    run_add("sub57", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    // 8000 - 1 = 7FFF, no borrow, signed overflow.
    run_add("sub8000", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    sub_i = 1'b0;
    run_add("sub_off", 16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Nibble-serial wide-operand adder that feeds the existing `full_adder_4bit` stage one nibble per cycle and consumes its result. It also registers the inter-nibble carry and reassembles the WIDTH-bit sum. It adds wide operands with a single 4-bit ripple adder, trading latency for area. The block sits between an operand producer (valid/ready source) and a result consumer (valid/ready sink).

## Interface
- `WIDTH`, default 16: operand/result width. Must be a multiple of 4 and ≥ 4. N = WIDTH/4 nibbles.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand set valid.
- `in_ready` output 1: block can accept operands. High only in IDLE.
- `a` input WIDTH: operand A, sampled on input handshake.
- `b` input WIDTH: operand B, sampled on input handshake.
- `cin` input 1: carry-in into nibble 0, sampled on input handshake.
- `sub` input 1: subtract select. Present only with `NSA_SUB_EN`.
- `sum` output WIDTH: registered result.
- `cout` output 1: carry out of nibble N-1.
- `overflow` output 1: signed two's-complement overflow of the full WIDTH result.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: nibble counter k = 0..N-1.
  - DONE: `out_valid`=1.
- IDLE → RUN when `in_valid && in_ready`.
  - Latch a, b and cin into internal registers.
  - Clear k to 0 and clear the sum register.
- RUN, each cycle:
  - Drive the 4-bit adder with a[4k+3:4k], b[4k+3:4k] and carry register c. For k=0, c is the latched cin.
  - Write the adder sum into sum[4k+3:4k] and the adder cout into c.
  - Increment k.
- RUN → DONE on the cycle k = N-1 completes.
  - `cout` = final carry.
  - `overflow` = (a[W-1]==b_eff[W-1]) && (sum[W-1]!=a[W-1]), computed from the final nibble.
- DONE → IDLE when `out_valid && out_ready`.
- Input changes after the handshake have no effect. Outputs stay stable throughout DONE.
- The outputs `sum`, `cout` and `overflow` are updated only by RUN. They hold their last value in IDLE.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values:
  - state = IDLE, so `in_ready`=1.
  - `out_valid`=0, `sum`=0, `cout`=0, `overflow`=0.
  - Internal carry and counter = 0.
- Latency: input handshake on edge E0. Nibbles are computed on edges E1..EN. `out_valid` is high after EN (N cycles).
- Minimum initiation interval is N+2 cycles: accept, N RUN cycles, output handshake, then back in IDLE. No overlap of accept and output.
- WIDTH=4: a single RUN cycle. `out_valid` follows the accept by 1 cycle.
- Backpressure: while `out_ready`=0 in DONE, all outputs are held and `in_ready`=0.
- `in_valid` asserted in RUN or DONE is ignored. The producer must hold it until `in_ready`.
- Reset asserted mid-RUN or in DONE:
  - Immediately abort to IDLE and clear all outputs.
  - `in_ready`=1 as soon as reset deasserts.
  - The partial result is discarded.

## Configuration
- `NSA_SUB_EN` defined:
  - Adds the `sub` port, latched on handshake.
  - sub=1: b_eff = ~b and carry-in = 1, with `cin` ignored. The block computes a − b. `cout`=1 means no borrow. `overflow` uses b_eff.
  - sub=0: behaves as addition.
- `NSA_SUB_EN` undefined:
  - No `sub` port. b_eff = b. Addition only.

## Test plan
- WIDTH=16. 0x1234 + 0x4321, cin=0 → sum=0x5555, cout=0, overflow=0. `out_valid` rises exactly 4 cycles after accept.
- 0xFFFF + 0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. The carry propagates through all 4 nibble cycles.
- 0x7FFF + 0x0001 → sum=0x8000, cout=0, overflow=1. Also 0x8000 + 0x8000 → sum=0x0000, cout=1, overflow=1.
- Hold `out_ready`=0 for 5 cycles in DONE:
  - `out_valid`, `sum`, `cout` and `overflow` stay constant, and `in_ready`=0.
  - A pulse on `in_valid` with new operands is ignored.
  - Raising `out_ready` → IDLE next cycle.
- Assert `rst` after 2 RUN cycles → `out_valid`=0, `sum`=0, `in_ready`=1. A new 0x0001 + 0x0001 then yields 0x0002.
- With `NSA_SUB_EN`: 0x0005 − 0x0007 (sub=1) → sum=0xFFFE, cout=0, overflow=0. Also 0x8000 − 0x0001 → sum=0x7FFF, cout=1, overflow=1.
